vx_warp_dvstack: RTL and testbench

//  Receiver end of the warp-control split/join channel: per-warp IPDOM divergence stack.
//  - Split pushes the reconvergence state for the warp; join pops it.
//  - Join returns the thread mask and PC to restore to the scheduler.
//  - Serves the combinational dvstack_ptr lookup that the issuing SFU captures at split time.

---
 rtl/vx_warp_dvstack.sv | 163 ++++++++++++++++
 tb/tb_vx_warp_dvstack.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_warp_dvstack.sv
// Per-warp IPDOM divergence stack: split pushes reconvergence state, join pops it.
// Optional performance counters are enabled with `define VX_DVSTACK_PERF_EN.
module vx_warp_dvstack #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH    = 32,
  parameter int STACK_DEPTH = 8,
  parameter int NW_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int PTR_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ctl_valid,
  input  logic [NW_W-1:0]        ctl_wid,
  input  logic                   split_valid,
  input  logic                   split_is_dvg,
  input  logic [NUM_THREADS-1:0] split_orig_tmask,
  input  logic [NUM_THREADS-1:0] split_else_tmask,
  input  logic [PC_WIDTH-1:0]    split_else_pc,
  input  logic                   join_valid,
  input  logic [PTR_W-1:0]       join_stack_ptr,
  input  logic [NW_W-1:0]        dvstack_wid,
  output logic [PTR_W-1:0]       dvstack_ptr,
  output logic                   join_out_valid,
  output logic [NW_W-1:0]        join_out_wid,
  output logic [NUM_THREADS-1:0] join_out_tmask,
  output logic [PC_WIDTH-1:0]    join_out_pc,
  output logic                   join_out_fallthru,
  output logic [NUM_WARPS-1:0]   warp_stall,
`ifdef VX_DVSTACK_PERF_EN
  output logic [31:0]            perf_splits,
  output logic [31:0]            perf_joins,
  output logic [PTR_W-1:0]       perf_max_depth,
`endif
  output logic                   err_overflow,
  output logic                   err_underflow
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_W-1:0] FULL_THR = PTR_W'(STACK_DEPTH - 2);

  logic [PTR_W-1:0]       ptr_q [NUM_WARPS];
  logic [PTR_W-1:0]       ptr_d [NUM_WARPS];
  logic [NUM_THREADS-1:0] stk_tmask_q [NUM_WARPS][STACK_DEPTH];
  logic [PC_WIDTH-1:0]    stk_pc_q    [NUM_WARPS][STACK_DEPTH];
  logic                   stk_ft_q    [NUM_WARPS][STACK_DEPTH];

  logic [PTR_W-1:0] cur_p;
  logic             push_en, pop_en, ovf_set, unf_set;
  logic [IDX_W-1:0] push_idx0, push_idx1, pop_idx;

  logic                   err_ovf_q, err_unf_q;
  logic                   jo_valid_q, jo_ft_q;
  logic [NW_W-1:0]        jo_wid_q;
  logic [NUM_THREADS-1:0] jo_tmask_q;
  logic [PC_WIDTH-1:0]    jo_pc_q;

  assign cur_p     = ptr_q[ctl_wid];
  assign push_idx0 = IDX_W'(cur_p);
  assign push_idx1 = IDX_W'(cur_p + PTR_W'(1));
  assign pop_idx   = IDX_W'(cur_p - PTR_W'(1));

  // A join always takes precedence; a split flagged alongside it is an error.
  always_comb begin
    ptr_d   = ptr_q;
    push_en = 1'b0;
    pop_en  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (ctl_valid) begin
      if (join_valid) begin
        if (split_valid) unf_set = 1'b1;
        if (join_stack_ptr != cur_p) begin
          if (cur_p == '0) begin
            unf_set = 1'b1;
          end else begin
            pop_en         = 1'b1;
            ptr_d[ctl_wid] = cur_p - PTR_W'(1);
          end
        end
      end else if (split_valid && split_is_dvg) begin
        if (cur_p > FULL_THR) begin
          ovf_set = 1'b1;
        end else begin
          push_en        = 1'b1;
          ptr_d[ctl_wid] = cur_p + PTR_W'(2);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) ptr_q[w] <= '0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
      jo_valid_q <= 1'b0;
      jo_wid_q   <= '0;
      jo_tmask_q <= '0;
      jo_pc_q    <= '0;
      jo_ft_q    <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      err_ovf_q  <= err_ovf_q | ovf_set;
      err_unf_q  <= err_unf_q | unf_set;
      jo_valid_q <= pop_en;
      if (pop_en) begin
        jo_wid_q   <= ctl_wid;
        jo_tmask_q <= stk_tmask_q[ctl_wid][pop_idx];
        jo_pc_q    <= stk_pc_q[ctl_wid][pop_idx];
        jo_ft_q    <= stk_ft_q[ctl_wid][pop_idx];
      end
    end
  end

  // Stack contents are pure data: validity is governed entirely by ptr_q.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stk_tmask_q[ctl_wid][push_idx0] <= split_orig_tmask;
      stk_pc_q[ctl_wid][push_idx0]    <= '0;
      stk_ft_q[ctl_wid][push_idx0]    <= 1'b1;
      stk_tmask_q[ctl_wid][push_idx1] <= split_else_tmask;
      stk_pc_q[ctl_wid][push_idx1]    <= split_else_pc;
      stk_ft_q[ctl_wid][push_idx1]    <= 1'b0;
    end
  end

`ifdef VX_DVSTACK_PERF_EN
  logic [31:0]      perf_splits_q, perf_joins_q;
  logic [PTR_W-1:0] perf_max_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_splits_q <= '0;
      perf_joins_q  <= '0;
      perf_max_q    <= '0;
    end else begin
      if (push_en) perf_splits_q <= perf_splits_q + 32'd1;
      if (pop_en)  perf_joins_q  <= perf_joins_q + 32'd1;
      if (push_en && (ptr_d[ctl_wid] > perf_max_q)) perf_max_q <= ptr_d[ctl_wid];
    end
  end

  assign perf_splits    = perf_splits_q;
  assign perf_joins     = perf_joins_q;
  assign perf_max_depth = perf_max_q;
`endif

  always_comb begin
    warp_stall = '0;
    for (int w = 0; w < NUM_WARPS; w++) warp_stall[w] = (ptr_q[w] > FULL_THR);
  end

  assign dvstack_ptr       = ptr_q[dvstack_wid];
  assign join_out_valid    = jo_valid_q;
  assign join_out_wid      = jo_wid_q;
  assign join_out_tmask    = jo_tmask_q;
  assign join_out_pc       = jo_pc_q;
  assign join_out_fallthru = jo_ft_q;
  assign err_overflow      = err_ovf_q;
  assign err_underflow     = err_unf_q;

endmodule

// File: tb/tb_vx_warp_dvstack.sv
// Directed self-checking bench for vx_warp_dvstack (default 4 warps, 4 threads, depth 8).
module tb_vx_warp_dvstack;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctl_valid;
  logic [1:0]  ctl_wid;
  logic        split_valid;
  logic        split_is_dvg;
  logic [3:0]  split_orig_tmask;
  logic [3:0]  split_else_tmask;
  logic [31:0] split_else_pc;
  logic        join_valid;
  logic [3:0]  join_stack_ptr;
  logic [1:0]  dvstack_wid;
  logic [3:0]  dvstack_ptr;
  logic        join_out_valid;
  logic [1:0]  join_out_wid;
  logic [3:0]  join_out_tmask;
  logic [31:0] join_out_pc;
  logic        join_out_fallthru;
  logic [3:0]  warp_stall;
  logic        err_overflow;
  logic        err_underflow;
`ifdef VX_DVSTACK_PERF_EN
  logic [31:0] perf_splits;
  logic [31:0] perf_joins;
  logic [3:0]  perf_max_depth;
`endif

  int checks = 0;
  int errors = 0;

  vx_warp_dvstack dut (
    .clk(clk), .reset(reset),
    .ctl_valid(ctl_valid), .ctl_wid(ctl_wid),
    .split_valid(split_valid), .split_is_dvg(split_is_dvg),
    .split_orig_tmask(split_orig_tmask), .split_else_tmask(split_else_tmask),
    .split_else_pc(split_else_pc),
    .join_valid(join_valid), .join_stack_ptr(join_stack_ptr),
    .dvstack_wid(dvstack_wid), .dvstack_ptr(dvstack_ptr),
    .join_out_valid(join_out_valid), .join_out_wid(join_out_wid),
    .join_out_tmask(join_out_tmask), .join_out_pc(join_out_pc),
    .join_out_fallthru(join_out_fallthru),
    .warp_stall(warp_stall),
`ifdef VX_DVSTACK_PERF_EN
    .perf_splits(perf_splits), .perf_joins(perf_joins), .perf_max_depth(perf_max_depth),
`endif
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ctl_valid = 0; ctl_wid = 0; split_valid = 0; split_is_dvg = 0;
    split_orig_tmask = 0; split_else_tmask = 0; split_else_pc = 0;
    join_valid = 0; join_stack_ptr = 0;
  endtask

  task automatic drive_split(input logic [1:0] w, input logic dvg, input logic [3:0] o,
                             input logic [3:0] e, input logic [31:0] pc);
    idle();
    ctl_valid = 1; ctl_wid = w; split_valid = 1; split_is_dvg = dvg;
    split_orig_tmask = o; split_else_tmask = e; split_else_pc = pc;
  endtask

  task automatic drive_join(input logic [1:0] w, input logic [3:0] jp);
    idle();
    ctl_valid = 1; ctl_wid = w; join_valid = 1; join_stack_ptr = jp;
  endtask

  task automatic chk_ptr(input string name, input logic [1:0] w, input logic [3:0] exp);
    dvstack_wid = w;
    #1;
    checks++;
    if (dvstack_ptr !== exp) begin
      errors++;
      $display("FAIL %s: dvstack_ptr(w%0d) got %0d expected %0d", name, w, dvstack_ptr, exp);
    end
  endtask

  task automatic chk_pop(input string name, input logic [1:0] w, input logic [3:0] tm,
                         input logic [31:0] pc, input logic ft);
    checks++;
    if (join_out_valid !== 1'b1 || join_out_wid !== w || join_out_tmask !== tm ||
        join_out_pc !== pc || join_out_fallthru !== ft) begin
      errors++;
      $display("FAIL %s: got v=%b w=%0d tm=%h pc=%h ft=%b expected v=1 w=%0d tm=%h pc=%h ft=%b",
               name, join_out_valid, join_out_wid, join_out_tmask, join_out_pc,
               join_out_fallthru, w, tm, pc, ft);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    idle();
    dvstack_wid = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    for (int w = 0; w < 4; w++) chk_ptr("reset_ptr", 2'(w), 4'd0);
    checks++;
    if (warp_stall !== 4'b0000) begin
      errors++;
      $display("FAIL reset_stall: got %b expected 0000", warp_stall);
    end
    chk_bit("reset_ovf", err_overflow, 1'b0);
    chk_bit("reset_unf", err_underflow, 1'b0);
    chk_bit("reset_jvalid", join_out_valid, 1'b0);
  endtask

  task automatic test_split_join();
    drive_split(2'd1, 1'b1, 4'b1111, 4'b0011, 32'h100);
    chk_ptr("split_prepush_ptr", 2'd1, 4'd0);
    tick(); idle();
    chk_ptr("split_ptr", 2'd1, 4'd2);
    chk_bit("split_no_jvalid", join_out_valid, 1'b0);
    drive_join(2'd1, 4'd0);
    tick(); idle();
    chk_pop("join1_else", 2'd1, 4'b0011, 32'h100, 1'b0);
    chk_ptr("join1_ptr", 2'd1, 4'd1);
    drive_join(2'd1, 4'd0);
    tick(); idle();
    chk_pop("join2_orig", 2'd1, 4'b1111, 32'h0, 1'b1);
    chk_ptr("join2_ptr", 2'd1, 4'd0);
    tick();
    chk_bit("join_pulse_end", join_out_valid, 1'b0);
  endtask

  task automatic test_nondiv();
    drive_split(2'd2, 1'b0, 4'b1111, 4'b0101, 32'h300);
    tick();
    drive_join(2'd2, 4'd0);
    tick(); idle();
    chk_bit("nondiv_no_jvalid", join_out_valid, 1'b0);
    chk_ptr("nondiv_ptr", 2'd2, 4'd0);
    chk_bit("nondiv_no_unf", err_underflow, 1'b0);
    chk_bit("nondiv_no_ovf", err_overflow, 1'b0);
  endtask

  task automatic test_overflow();
    logic [3:0]  o [4] = '{4'hF, 4'hE, 4'hD, 4'hC};
    logic [3:0]  e [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    logic [31:0] p [4] = '{32'h200, 32'h210, 32'h220, 32'h230};
    for (int k = 0; k < 4; k++) begin
      drive_split(2'd0, 1'b1, o[k], e[k], p[k]);
      tick(); idle();
      if (k == 2) begin
        chk_ptr("ovf_ptr6", 2'd0, 4'd6);
        chk_bit("ovf_nostall_at6", warp_stall[0], 1'b0);
      end
    end
    chk_ptr("ovf_ptr8", 2'd0, 4'd8);
    checks++;
    if (warp_stall !== 4'b0001) begin
      errors++;
      $display("FAIL ovf_stall: got %b expected 0001", warp_stall);
    end
    chk_bit("ovf_not_yet", err_overflow, 1'b0);
    drive_split(2'd0, 1'b1, 4'h9, 4'h6, 32'hDEAD);
    tick(); idle();
    chk_ptr("ovf_drop_ptr", 2'd0, 4'd8);
    chk_bit("ovf_flag", err_overflow, 1'b1);
    chk_bit("ovf_no_unf", err_underflow, 1'b0);
    for (int w = 1; w < 4; w++) chk_ptr("ovf_other_ptr", 2'(w), 4'd0);
  endtask

  task automatic test_underflow();
    drive_join(2'd3, 4'd1);
    tick(); idle();
    chk_bit("unf_flag", err_underflow, 1'b1);
    chk_bit("unf_no_jvalid", join_out_valid, 1'b0);
    chk_ptr("unf_ptr", 2'd3, 4'd0);
    drive_join(2'd0, 4'd0);
    split_valid = 1; split_is_dvg = 1;
    split_orig_tmask = 4'hA; split_else_tmask = 4'h5; split_else_pc = 32'hBAD;
    tick(); idle();
    chk_pop("both_join_only", 2'd0, 4'h4, 32'h230, 1'b0);
    chk_ptr("both_ptr", 2'd0, 4'd7);
    chk_bit("both_unf_sticky", err_underflow, 1'b1);
    chk_bit("both_ovf_sticky", err_overflow, 1'b1);
  endtask

  task automatic test_back_to_back();
    drive_join(2'd0, 4'd0);
    tick();
    chk_pop("b2b_pop6", 2'd0, 4'hC, 32'h0, 1'b1);
    tick();
    chk_pop("b2b_pop5", 2'd0, 4'h3, 32'h220, 1'b0);
    tick(); idle();
    chk_pop("b2b_pop4", 2'd0, 4'hD, 32'h0, 1'b1);
    chk_ptr("b2b_ptr", 2'd0, 4'd4);
    checks++;
    if (warp_stall !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_stall: got %b expected 0000", warp_stall);
    end
  endtask

  task automatic test_reset_inflight();
`ifdef VX_DVSTACK_PERF_EN
    checks++;
    if (perf_splits !== 32'd5 || perf_joins !== 32'd6 || perf_max_depth !== 4'd8) begin
      errors++;
      $display("FAIL perf_counts: got s=%0d j=%0d m=%0d expected s=5 j=6 m=8",
               perf_splits, perf_joins, perf_max_depth);
    end
`endif
    drive_join(2'd0, 4'd0);
    reset = 1;
    tick();
    reset = 0; idle();
    chk_bit("rst_jvalid", join_out_valid, 1'b0);
    chk_ptr("rst_ptr", 2'd0, 4'd0);
    chk_bit("rst_ovf", err_overflow, 1'b0);
    chk_bit("rst_unf", err_underflow, 1'b0);
`ifdef VX_DVSTACK_PERF_EN
    checks++;
    if (perf_splits !== 32'd0 || perf_max_depth !== 4'd0 || perf_joins !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: got s=%0d j=%0d m=%0d expected 0", perf_splits,
               perf_joins, perf_max_depth);
    end
`endif
  endtask

  initial begin
    reset = 1;
    dvstack_wid = 0;
    idle();
    test_reset();
    test_split_join();
    test_nondiv();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
